// File: rtl/param_nibble_core.sv
`default_nettype none
// ============================================================================
// Module   : param_nibble_core
// Brief    : Parametrised multicycle accumulator core (fetch/decode/exec/wb)
//            with an external synchronous instruction ROM and internal RAM.
// Revision : 1.0 - initial release
// ============================================================================
module param_nibble_core #(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 5,
  parameter  int PC_W    = 5,
  localparam int INSTR_W = 4 + ADDR_W + 2 * DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [DATA_W-1:0]  r,
  output logic [DATA_W-1:0]  x,
  output logic [DATA_W-1:0]  y,
  output logic [ADDR_W-1:0]  addr,
  output logic [3:0]         op,
  output logic [PC_W-1:0]    pc,
  output logic               zero,
  output logic               carry,
  output logic               instr_done,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADDI  = 4'd0;
  localparam logic [3:0] OP_ADDM  = 4'd1;
  localparam logic [3:0] OP_SUBI  = 4'd2;
  localparam logic [3:0] OP_SUBM  = 4'd3;
  localparam logic [3:0] OP_ANDM  = 4'd4;
  localparam logic [3:0] OP_ORM   = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd9;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   r_q, r_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          op_q, op_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem_q [0:(2**ADDR_W)-1];

  logic [DATA_W-1:0]   w_opa;
  logic [DATA_W:0]     w_add;
  logic [DATA_W:0]     w_sub;

  // Immediate forms take y as the left operand, memory forms take the RAM word.
  always_comb begin
    w_opa = ((op_q == OP_ADDI) || (op_q == OP_SUBI)) ? y_q : rd_q;
    w_add = {1'b0, w_opa} + {1'b0, x_q};
    w_sub = {1'b0, w_opa} + {1'b0, ~x_q} + {{DATA_W{1'b0}}, 1'b1};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    op_d    = op_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    rd_d    = rd_q;
    mem_we  = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        {op_d, addr_d, x_d, y_d} = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rd_d    = mem_q[addr_q];
        state_d = S_WB;
      end
      S_WB: begin
        state_d = (op_q == OP_HALT) ? S_HALT : S_FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (op_q)
          OP_ADDI, OP_ADDM: begin
            r_d     = w_add[DATA_W-1:0];
            carry_d = w_add[DATA_W];
            zero_d  = (w_add[DATA_W-1:0] == '0);
          end
          OP_SUBI, OP_SUBM: begin
            r_d     = w_sub[DATA_W-1:0];
            carry_d = w_sub[DATA_W];
            zero_d  = (w_sub[DATA_W-1:0] == '0);
          end
          OP_ANDM: begin
            r_d     = rd_q & x_q;
            carry_d = 1'b0;
            zero_d  = ((rd_q & x_q) == '0);
          end
          OP_ORM: begin
            r_d     = rd_q | x_q;
            carry_d = 1'b0;
            zero_d  = ((rd_q | x_q) == '0);
          end
          OP_STORE: mem_we = 1'b1;
          OP_JMP:   pc_d = y_q[PC_W-1:0];
          OP_JZ:    if (zero_q) pc_d = y_q[PC_W-1:0];
          OP_HALT:  pc_d = pc_q;
          default: ;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // RAM contents survive reset; the write strobe drops as soon as state_q clears.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
    if (mem_we) mem_q[addr_q] <= r_q;
  end

  assign imem_addr  = pc_q;
  assign dbg_data   = mem_q[dbg_addr];
  assign r          = r_q;
  assign x          = x_q;
  assign y          = y_q;
  assign addr       = addr_q;
  assign op         = op_q;
  assign pc         = pc_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign instr_done = (state_q == S_WB);
  assign halted     = (state_q == S_HALT);

endmodule
`default_nettype wire
